// File: rtl/done_signal_pio_in.sv
// Avalon-MM input PIO that reports accelerator status to software.
// Each status line is synchronised, edge-detected and latched into a
// write-1-to-clear capture register. New captures bump a saturating event
// counter, and masked captures raise a level interrupt.
module done_signal_pio_in #(
    parameter int unsigned WIDTH     = 1,  // number of status lines, 1..32
    parameter int unsigned EDGE_TYPE = 0,  // 0 = rising, 1 = falling, 2 = any
    parameter int unsigned CNT_W     = 16  // event counter width, 1..32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // Register map word addresses
    localparam logic [1:0] AddrData    = 2'd0;
    localparam logic [1:0] AddrCount   = 2'd1;
    localparam logic [1:0] AddrIrqMask = 2'd2;
    localparam logic [1:0] AddrEdgeCap = 2'd3;

    localparam logic [CNT_W-1:0] CountMax = {CNT_W{1'b1}};

    // Synchroniser and edge-detect pipeline
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] capture;

    // Arm counter
    logic [1:0]       arm;
    logic             armed;

    // Software-visible state
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] edgecap_next;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] irqmask_next;
    logic [WIDTH-1:0] w1c_bits;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             new_event;

    // Bus decode
    logic             wr_en;
    logic             rd_en;
    logic [31:0]      rd_mux;

    // Upper writedata bits only matter for wide configurations
    logic             unused_writedata;
    assign unused_writedata = ^writedata;

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & read;

    // Two-flop synchroniser plus a history flop for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= in_port;
            s2   <= s1;
            prev <= s2;
        end
    end

    // Arm counter: hold off captures until the sync pipeline holds real history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm <= 2'd0;
        end else if (arm != 2'd3) begin
            arm <= arm + 2'd1;
        end
    end

    assign armed = (arm == 2'd3);

    // Edge selection by configured polarity
    always_comb begin
        rise = s2 & ~prev;
        fall = ~s2 & prev;
        if (EDGE_TYPE == 0) begin
            edge_hit = rise;
        end else if (EDGE_TYPE == 1) begin
            edge_hit = fall;
        end else begin
            edge_hit = rise | fall;
        end
        capture   = armed ? edge_hit : '0;
        // Only bits not already latched count as new events
        new_event = |(capture & ~edgecap);
    end

    // Next-state for edge capture, mask and event counter
    always_comb begin
        w1c_bits     = '0;
        irqmask_next = irqmask;
        count_next   = count;

        if (wr_en && (address == AddrEdgeCap)) begin
            w1c_bits = writedata[WIDTH-1:0];
        end
        // Set after clear so a same-cycle capture is never lost
        edgecap_next = (edgecap & ~w1c_bits) | capture;

        if (wr_en && (address == AddrIrqMask)) begin
            irqmask_next = writedata[WIDTH-1:0];
        end

        if (wr_en && (address == AddrCount)) begin
            // A clear racing an event keeps that event
            count_next = new_event ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        end else if (new_event && (count != CountMax)) begin
            count_next = count + 1'b1;
        end
    end

    // Software-visible registers and registered interrupt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edgecap <= '0;
            irqmask <= '0;
            count   <= '0;
            irq     <= 1'b0;
        end else begin
            edgecap <= edgecap_next;
            irqmask <= irqmask_next;
            count   <= count_next;
            irq     <= |(edgecap_next & irqmask);
        end
    end

    // Read mux over pre-update register state, zero-extended
    always_comb begin
        rd_mux = '0;
        unique case (address)
            AddrData:    rd_mux[WIDTH-1:0] = s2;
            AddrCount:   rd_mux[CNT_W-1:0] = count;
            AddrIrqMask: rd_mux[WIDTH-1:0] = irqmask;
            AddrEdgeCap: rd_mux[WIDTH-1:0] = edgecap;
            default:     rd_mux = '0;
        endcase
    end

    // Read data register: one-cycle latency, holds between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_done_signal_pio_in.sv
// Directed bench for done_signal_pio_in: a rising-edge 4-bit instance for the
// register map, irq and same-cycle corners, and an any-edge 4-bit counter
// instance for saturation.
module tb_done_signal_pio_in;

    localparam int OpRd  = 0;  // read addr, compare to exp
    localparam int OpWr  = 1;  // write data to addr
    localparam int OpIn  = 2;  // drive in_port_a = data, wait exp cycles
    localparam int OpIrq = 3;  // wait one cycle, compare irq_a to exp[0]
    localparam int OpRst = 4;  // pulse reset with in_port_a = data held

    typedef struct {
        int          op;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata_a;
    logic [31:0] readdata_b;
    logic [3:0]  in_port_a;
    logic [3:0]  in_port_b;
    logic        irq_a;
    logic        irq_b;

    int n_checks;
    int n_fail;

    vec_t vecs[$];

    done_signal_pio_in #(
        .WIDTH     (4),
        .EDGE_TYPE (0),
        .CNT_W     (16)
    ) dut_a (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata_a),
        .in_port    (in_port_a),
        .irq        (irq_a)
    );

    done_signal_pio_in #(
        .WIDTH     (4),
        .EDGE_TYPE (2),
        .CNT_W     (4)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata_b),
        .in_port    (in_port_b),
        .irq        (irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] da,
                            output logic [31:0] db);
        address    = a;
        chipselect = 1'b1;
        read       = 1'b1;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read       = 1'b0;
        da         = readdata_a;
        db         = readdata_b;
    endtask

    // Change in_port_a so its edge reaches the capture stage on the write edge
    task automatic same_cycle_write(input logic [3:0] new_in, input logic [1:0] a,
                                    input logic [31:0] d);
        in_port_a = new_in;
        wait_cycles(2);
        bus_write(a, d);
    endtask

    function automatic void add(input int op, input logic [1:0] a, input logic [31:0] d,
                                input logic [31:0] e);
        vec_t v;
        v.op   = op;
        v.addr = a;
        v.data = d;
        v.exp  = e;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        read       = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port_a  = 4'h0;
        in_port_b  = 4'h0;

        // Reset-time outputs
        wait_cycles(2);
        check("reset_readdata", readdata_a, 32'h0);
        check("reset_irq", {31'h0, irq_a}, 32'h0);
        reset = 1'b0;
        wait_cycles(1);

        // Register map after reset
        add(OpRd, 2'd0, 0, 32'h0);
        add(OpRd, 2'd1, 0, 32'h0);
        add(OpRd, 2'd2, 0, 32'h0);
        add(OpRd, 2'd3, 0, 32'h0);
        add(OpIrq, 2'd0, 0, 32'h0);
        // Line already high through reset release: no spurious capture
        add(OpRst, 2'd0, 32'h8, 0);
        add(OpIn, 2'd0, 32'h8, 32'd10);
        add(OpRd, 2'd3, 0, 32'h0);
        add(OpRd, 2'd1, 0, 32'h0);
        add(OpRd, 2'd0, 0, 32'h8);
        // Rising on bits 0,2; falling bit 3 ignored; one event for the cycle
        add(OpIn, 2'd0, 32'h5, 32'd4);
        add(OpRd, 2'd3, 0, 32'h5);
        add(OpRd, 2'd0, 0, 32'h5);
        add(OpRd, 2'd1, 0, 32'h1);
        add(OpIrq, 2'd0, 0, 32'h0);
        add(OpRd, 2'd2, 0, 32'h0);
        // Mask and W1C interplay with irq
        add(OpWr, 2'd2, 32'h4, 0);
        add(OpIrq, 2'd0, 0, 32'h1);
        add(OpRd, 2'd2, 0, 32'h4);
        add(OpWr, 2'd3, 32'h4, 0);
        add(OpIrq, 2'd0, 0, 32'h0);
        add(OpRd, 2'd3, 0, 32'h1);
        add(OpWr, 2'd3, 32'h1, 0);
        add(OpRd, 2'd3, 0, 32'h0);
        add(OpWr, 2'd0, 32'hF, 0);
        add(OpRd, 2'd0, 0, 32'h5);
        add(OpRd, 2'd1, 0, 32'h1);
        // Bit 1 rise, then fall (not captured)
        add(OpIn, 2'd0, 32'h7, 32'd4);
        add(OpRd, 2'd3, 0, 32'h2);
        add(OpRd, 2'd1, 0, 32'h2);
        add(OpIn, 2'd0, 32'h5, 32'd4);
        add(OpRd, 2'd3, 0, 32'h2);

        for (int i = 0; i < vecs.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            case (vecs[i].op)
                OpRd: begin
                    bus_read(vecs[i].addr, ra, rb);
                    check(nm, ra, vecs[i].exp);
                end
                OpWr: bus_write(vecs[i].addr, vecs[i].data);
                OpIn: begin
                    in_port_a = vecs[i].data[3:0];
                    wait_cycles(int'(vecs[i].exp));
                end
                OpIrq: begin
                    wait_cycles(1);
                    check(nm, {31'h0, irq_a}, vecs[i].exp);
                end
                default: begin
                    reset     = 1'b1;
                    in_port_a = vecs[i].data[3:0];
                    wait_cycles(2);
                    reset     = 1'b0;
                end
            endcase
        end

        // Same-cycle W1C and re-capture of bit 1: set wins, no new count
        same_cycle_write(4'h7, 2'd3, 32'h2);
        bus_read(2'd3, ra, rb);
        check("w1c_vs_set_edgecap", ra, 32'h2);
        bus_read(2'd1, ra, rb);
        check("w1c_vs_set_count", ra, 32'h2);

        // Same-cycle COUNT clear and new capture on bit 3: count = 1
        same_cycle_write(4'hF, 2'd1, 32'h0);
        bus_read(2'd1, ra, rb);
        check("clr_vs_inc_count", ra, 32'h1);
        bus_read(2'd3, ra, rb);
        check("clr_vs_inc_edgecap", ra, 32'hA);
        bus_write(2'd1, 32'h0);
        bus_read(2'd1, ra, rb);
        check("count_clear", ra, 32'h0);
        bus_write(2'd2, 32'h8);
        wait_cycles(1);
        check("irq_mask8", {31'h0, irq_a}, 32'h1);

        // Build edgecap=0x3 with irq high, then reset mid-cycle
        bus_write(2'd3, 32'hF);
        in_port_a = 4'hC;
        wait_cycles(4);
        in_port_a = 4'hF;
        wait_cycles(4);
        bus_write(2'd2, 32'h1);
        wait_cycles(1);
        check("irq_before_reset", {31'h0, irq_a}, 32'h1);
        bus_read(2'd3, ra, rb);
        check("edgecap_before_reset", ra, 32'h3);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_irq", {31'h0, irq_a}, 32'h0);
        check("async_reset_readdata", readdata_a, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_cycles(10);
        bus_read(2'd0, ra, rb);
        check("post_reset_data", ra, 32'hF);
        bus_read(2'd1, ra, rb);
        check("post_reset_count", ra, 32'h0);
        bus_read(2'd2, ra, rb);
        check("post_reset_mask", ra, 32'h0);
        bus_read(2'd3, ra, rb);
        check("post_reset_edgecap", ra, 32'h0);
        check("post_reset_irq", {31'h0, irq_a}, 32'h0);
        in_port_a = 4'hE;
        wait_cycles(4);
        in_port_a = 4'hF;
        wait_cycles(4);
        bus_read(2'd3, ra, rb);
        check("rearmed_capture", ra, 32'h1);

        // Any-edge counter saturates at 15 over 20 toggles
        bus_write(2'd1, 32'h0);
        bus_write(2'd3, 32'hF);
        for (int i = 1; i <= 20; i++) begin
            in_port_b[0] = ~in_port_b[0];
            wait_cycles(4);
            bus_write(2'd3, 32'h1);
            if (i == 10) begin
                bus_read(2'd1, ra, rb);
                check("count_b_10", rb, 32'd10);
            end
        end
        bus_read(2'd1, ra, rb);
        check("count_b_sat", rb, 32'd15);
        bus_read(2'd3, ra, rb);
        check("edgecap_b_cleared", rb, 32'h0);
        bus_read(2'd0, ra, rb);
        check("data_b", rb, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
